// File: rtl/reg_serializer.sv
// reg_serializer: parallel-load, valid/ready bit-serial transmitter.
// Emits a Size-bit word one bit per accepted transfer, then pulses done_o.
module reg_serializer #(
  parameter int Size     = 8,
  parameter bit MsbFirst = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [Size-1:0] data_i,
  input  logic            writeEn,
  input  logic            ready_i,
  output logic            data_o,
  output logic            valid_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int CntW = (Size > 1) ? $clog2(Size) : 1;
  localparam int OutBit = MsbFirst ? Size - 1 : 0;
  localparam logic [CntW-1:0] CntMax = CntW'(Size - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [Size-1:0] sreg_q, sreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    data_o  = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (writeEn) begin
          sreg_d  = data_i;
          cnt_d   = CntMax;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
        data_o  = sreg_q[OutBit];
        last_o  = (cnt_q == '0);
        // Shift only on an accepted transfer so the bit is stable under stall
        if (ready_i) begin
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            sreg_d = MsbFirst ? (sreg_q << 1) : (sreg_q >> 1);
            cnt_d  = cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        busy_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
